// File: rtl/master_trig_pkg.sv
// master_trig_pkg: shared types and sizes for the master-trigger readout path.
package master_trig_pkg;
  localparam int TRIG_ADDR_BITS = 12;
  localparam int TRIG_META_BITS = 64;
  typedef enum logic [2:0] {IDLE, READ, WAIT, CLEAR, OUT} state_t;
  typedef struct packed {
    logic [TRIG_ADDR_BITS-1:0] addr;
    logic [TRIG_META_BITS-1:0] metadata;
  } trig_entry_t;
endpackage

// File: rtl/master_trig_sat_counter.sv
// master_trig_sat_counter: event counter that sticks at all-ones.
module master_trig_sat_counter #(
  parameter int W = 32
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         i_inc,
  output logic [W-1:0] o_count
);
  logic [W-1:0] r_count;
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) r_count <= '0;
    else if (i_inc && !(&r_count)) r_count <= r_count + 1'b1;
  assign o_count = r_count;
endmodule

// File: rtl/master_trig_readout.sv
// master_trig_readout: scans the trigger URAM behind the write pointer, clears each
// set entry and then offers {address, metadata} downstream.
module master_trig_readout
  import master_trig_pkg::*;
#(
  parameter int ADDR_BITS  = TRIG_ADDR_BITS,
  parameter int COUNT_BITS = 32
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      run_i,
  input  logic [ADDR_BITS-1:0]      wr_ptr_i,
  output logic [ADDR_BITS-1:0]      uram_raddr_o,
  output logic                      uram_rd_en_o,
  output logic                      uram_rd_phase_o,
  input  logic [TRIG_META_BITS-1:0] uram_metadata_i,
  input  logic                      uram_trigger_i,
  output logic                      m_valid_o,
  input  logic                      m_ready_i,
  output logic [ADDR_BITS-1:0]      m_addr_o,
  output logic [TRIG_META_BITS-1:0] m_metadata_o,
  output logic [COUNT_BITS-1:0]     trig_count_o,
  output logic [COUNT_BITS-1:0]     drop_count_o,
  output logic                      busy_o
);
  state_t                r_state, w_next;
  logic [ADDR_BITS-1:0]  r_rptr, w_rptr_inc;
  trig_entry_t           r_entry;
  logic                  w_adv, w_emit, w_drop;
  assign w_rptr_inc = r_rptr + 1'b1;
  always_comb begin
    w_next = r_state;
    w_adv  = 1'b0;
    w_emit = 1'b0;
    w_drop = 1'b0;
    case (r_state)
      IDLE:  w_next = (r_rptr != wr_ptr_i) ? READ : IDLE;
      READ:  w_next = WAIT;
      WAIT: begin
        w_adv  = !uram_trigger_i;
        w_next = uram_trigger_i ? CLEAR : ((w_rptr_inc != wr_ptr_i) ? READ : IDLE);
      end
      CLEAR: begin
        w_drop = !run_i;
        w_adv  = !run_i;
        w_next = run_i ? OUT : IDLE;
      end
      OUT: begin
        w_emit = m_ready_i;
        w_adv  = m_ready_i;
        w_next = m_ready_i ? IDLE : OUT;
      end
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      r_state <= IDLE;
      r_rptr  <= '0;
      r_entry <= '0;
    end else begin
      r_state <= w_next;
      if (w_adv) r_rptr <= w_rptr_inc;
      if (r_state == WAIT) r_entry <= '{addr: TRIG_ADDR_BITS'(r_rptr), metadata: uram_metadata_i};
    end
  // The clear strobe precedes OUT, so a stalled consumer never leaves a stale trigger bit.
  assign uram_raddr_o    = r_rptr;
  assign uram_rd_en_o    = (r_state == READ) || (r_state == CLEAR);
  assign uram_rd_phase_o = (r_state == CLEAR);
  assign m_valid_o       = (r_state == OUT);
  assign busy_o          = (r_state != IDLE);
  assign m_addr_o        = ADDR_BITS'(r_entry.addr);
  assign m_metadata_o    = r_entry.metadata;
  master_trig_sat_counter #(.W(COUNT_BITS)) u_trig_cnt (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .i_inc   (w_emit),
    .o_count (trig_count_o)
  );
  master_trig_sat_counter #(.W(COUNT_BITS)) u_drop_cnt (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .i_inc   (w_drop),
    .o_count (drop_count_o)
  );
endmodule

// File: tb/tb_master_trig_readout.sv
// tb_master_trig_readout: URAM model plus scan-order reference for master_trig_readout.
module tb_master_trig_readout;
  localparam int N = 4096;
  localparam logic [63:0] DEAD = 64'hDEAD_BEEF_0123_4567;
  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        run_i = 1'b1;
  logic [11:0] wr_ptr_i = '0;
  logic [11:0] uram_raddr_o;
  logic        uram_rd_en_o, uram_rd_phase_o;
  logic [63:0] uram_metadata_i = '0;
  logic        uram_trigger_i = 1'b0;
  logic        m_valid_o;
  logic        m_ready_i;
  logic [11:0] m_addr_o;
  logic [63:0] m_metadata_o;
  logic [31:0] trig_count_o, drop_count_o;
  logic        busy_o;
  always #5 clk_i = ~clk_i;
  master_trig_readout dut (
    .clk_i(clk_i), .rst_i(rst_i), .run_i(run_i), .wr_ptr_i(wr_ptr_i),
    .uram_raddr_o(uram_raddr_o), .uram_rd_en_o(uram_rd_en_o), .uram_rd_phase_o(uram_rd_phase_o),
    .uram_metadata_i(uram_metadata_i), .uram_trigger_i(uram_trigger_i),
    .m_valid_o(m_valid_o), .m_ready_i(m_ready_i), .m_addr_o(m_addr_o), .m_metadata_o(m_metadata_o),
    .trig_count_o(trig_count_o), .drop_count_o(drop_count_o), .busy_o(busy_o)
  );
  logic        mem_trig [N];
  logic [63:0] mem_meta [N];
  logic        ld_en = 1'b0, wipe = 1'b0;
  logic [11:0] ld_a = '0;
  logic [63:0] ld_m = '0;
  always @(posedge clk_i) begin
    if (wipe) begin
      for (int i = 0; i < N; i++) begin
        mem_trig[i] <= 1'b0;
        mem_meta[i] <= '0;
      end
    end else if (ld_en) begin
      mem_trig[ld_a] <= 1'b1;
      mem_meta[ld_a] <= ld_m;
    end else if (uram_rd_en_o) begin
      if (uram_rd_phase_o) begin
        mem_trig[uram_raddr_o] <= 1'b0;
        mem_meta[uram_raddr_o] <= '0;
      end else begin
        uram_trigger_i  <= mem_trig[uram_raddr_o];
        uram_metadata_i <= mem_meta[uram_raddr_o];
      end
    end
  end
  typedef struct packed {logic ph; logic [11:0] a;} stb_t;
  typedef struct packed {logic [11:0] a; logic [63:0] m;} em_t;
  stb_t s_q[$];
  int   s_cyc[$];
  em_t  e_q[$];
  int   cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;
  always @(negedge clk_i)
    if (!rst_i) begin
      if (uram_rd_en_o) begin
        s_q.push_back({uram_rd_phase_o, uram_raddr_o});
        s_cyc.push_back(cyc);
      end
      if (m_valid_o && m_ready_i) e_q.push_back({m_addr_o, m_metadata_o});
    end
  logic rdy_rand = 1'b0, rdy_force = 1'b1;
  initial begin
    m_ready_i = 1'b1;
    forever begin
      @(posedge clk_i);
      #1;
      m_ready_i = rdy_rand ? 1'($urandom_range(0, 1)) : rdy_force;
    end
  end
  int n_chk = 0, n_fail = 0;
  task automatic chk(input string tag, input logic [95:0] got, input logic [95:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  bit          g_trig [N];
  logic [63:0] g_meta [N];
  int   mp, exp_trig, exp_drop, s_base, e_base;
  stb_t xs[$];
  em_t  xe[$];
  task automatic load(input int a, input logic [63:0] m);
    ld_a = 12'(a);
    ld_m = m;
    ld_en = 1'b1;
    @(posedge clk_i);
    #1 ld_en = 1'b0;
    g_trig[a] = 1'b1;
    g_meta[a] = m;
  endtask
  task automatic do_reset();
    @(negedge clk_i);
    rst_i = 1'b1;
    wr_ptr_i = '0;
    wipe = 1'b1;
    @(posedge clk_i);
    #1 wipe = 1'b0;
    for (int i = 0; i < N; i++) g_trig[i] = 1'b0;
    @(negedge clk_i);
    rst_i = 1'b0;
    mp = 0;
    exp_trig = 0;
    exp_drop = 0;
  endtask
  // Reference: walk addresses mp..new_wr-1; each set entry is read, cleared, then emitted or dropped.
  task automatic scan_begin(input int new_wr);
    xs.delete();
    xe.delete();
    s_base = s_q.size();
    e_base = e_q.size();
    for (int a = mp; a != new_wr; a = (a + 1) % N) begin
      xs.push_back({1'b0, 12'(a)});
      if (g_trig[a]) begin
        xs.push_back({1'b1, 12'(a)});
        if (run_i) begin
          xe.push_back({12'(a), g_meta[a]});
          exp_trig++;
        end else exp_drop++;
        g_trig[a] = 1'b0;
      end
    end
    mp = new_wr;
    @(negedge clk_i);
    wr_ptr_i = 12'(new_wr);
  endtask
  task automatic scan_end(input string tag, input int budget);
    bit done = 1'b0;
    bit bad = 1'b0;
    @(negedge clk_i);
    for (int k = 0; k < budget && !done; k++) begin
      @(negedge clk_i);
      done = !busy_o && (uram_raddr_o == 12'(mp));
    end
    chk({tag, " done"}, 96'(done), 96'(1'b1));
    chk({tag, " strobes"}, 96'(s_q.size() - s_base), 96'(xs.size()));
    for (int i = 0; i < xs.size() && s_base + i < s_q.size() && !bad; i++) begin
      chk({tag, " strobe"}, 96'(s_q[s_base+i]), 96'(xs[i]));
      bad = (s_q[s_base+i] !== xs[i]);
    end
    bad = 1'b0;
    chk({tag, " emits"}, 96'(e_q.size() - e_base), 96'(xe.size()));
    for (int i = 0; i < xe.size() && e_base + i < e_q.size() && !bad; i++) begin
      chk({tag, " emit"}, 96'(e_q[e_base+i]), 96'(xe[i]));
      bad = (e_q[e_base+i] !== xe[i]);
    end
    chk({tag, " trig_count"}, 96'(trig_count_o), 96'(exp_trig));
    chk({tag, " drop_count"}, 96'(drop_count_o), 96'(exp_drop));
    for (int i = 0; i < xs.size(); i++)
      if (xs[i].ph) chk({tag, " cleared"}, 96'(mem_trig[xs[i].a]), 96'(1'b0));
  endtask
  task automatic chk_zero(input string tag);
    chk({tag, " raddr"}, 96'(uram_raddr_o), 96'(0));
    chk({tag, " rd_en"}, 96'(uram_rd_en_o), 96'(0));
    chk({tag, " rd_phase"}, 96'(uram_rd_phase_o), 96'(0));
    chk({tag, " valid"}, 96'(m_valid_o), 96'(0));
    chk({tag, " m_addr"}, 96'(m_addr_o), 96'(0));
    chk({tag, " m_meta"}, 96'(m_metadata_o), 96'(0));
    chk({tag, " trig_count"}, 96'(trig_count_o), 96'(0));
    chk({tag, " drop_count"}, 96'(drop_count_o), 96'(0));
    chk({tag, " busy"}, 96'(busy_o), 96'(0));
  endtask
  initial begin
    int nsb, k, len, base;
    bit seen;
    do_reset();
    chk_zero("reset");
    // empty scan: five reads on alternating cycles
    scan_begin(5);
    scan_end("empty", 100);
    for (int i = 1; i < 5; i++)
      if (s_base + i < s_cyc.size()) chk("empty spacing", 96'(s_cyc[s_base+i] - s_cyc[s_base+i-1]), 96'(2));
    // single trigger
    do_reset();
    load(3, DEAD);
    scan_begin(8);
    scan_end("single", 100);
    chk("single meta cleared", 96'(mem_meta[3]), 96'(0));
    // backpressure
    do_reset();
    load(3, DEAD);
    rdy_force = 1'b0;
    scan_begin(8);
    seen = 1'b0;
    for (k = 0; k < 50 && !seen; k++) begin
      @(negedge clk_i);
      seen = m_valid_o;
    end
    chk("bp valid seen", 96'(seen), 96'(1'b1));
    nsb = s_q.size();
    repeat (20) begin
      @(negedge clk_i);
      chk("bp valid", 96'(m_valid_o), 96'(1'b1));
      chk("bp addr", 96'(m_addr_o), 96'(3));
      chk("bp meta", 96'(m_metadata_o), 96'(DEAD));
      chk("bp rd_en", 96'(uram_rd_en_o), 96'(0));
    end
    chk("bp no reads", 96'(s_q.size()), 96'(nsb));
    chk("bp count held", 96'(trig_count_o), 96'(0));
    rdy_force = 1'b1;
    scan_end("bp", 100);
    // drain across a full wrap
    do_reset();
    run_i = 1'b0;
    load(1, 64'h1111);
    load(2, 64'h2222);
    load(4095, 64'hFFFF);
    scan_begin(4095);
    scan_end("drain a", 9000);
    scan_begin(0);
    scan_end("drain b", 50);
    chk("drain total", 96'(drop_count_o), 96'(3));
    // wrap and limit
    do_reset();
    run_i = 1'b1;
    scan_begin(4094);
    scan_end("wrap pre", 9000);
    load(0, {$urandom, $urandom});
    scan_begin(1);
    scan_end("wrap", 50);
    // asynchronous reset while clearing
    do_reset();
    load(2, 64'hABCD);
    scan_begin(6);
    seen = 1'b0;
    for (k = 0; k < 50 && !seen; k++) begin
      @(negedge clk_i);
      seen = uram_rd_en_o && uram_rd_phase_o;
    end
    chk("clear seen", 96'(seen), 96'(1'b1));
    #2 rst_i = 1'b1;
    wr_ptr_i = '0;
    #1 chk_zero("async rst");
    @(posedge clk_i);
    #1 chk("aborted clear", 96'(mem_trig[2]), 96'(1'b1));
    @(negedge clk_i);
    rst_i = 1'b0;
    mp = 0;
    exp_trig = 0;
    exp_drop = 0;
    g_trig[2] = 1'b1;
    scan_begin(6);
    scan_end("post rst", 100);
    // randomized windows, run mode and downstream readiness
    rdy_rand = 1'b1;
    for (int r = 0; r < 8; r++) begin
      run_i = 1'($urandom_range(0, 1));
      len = $urandom_range(1, 200);
      base = mp;
      for (int j = 0; j < int'($urandom_range(0, 12)); j++)
        load((base + int'($urandom_range(0, len - 1))) % N, {$urandom, $urandom});
      scan_begin((base + len) % N);
      scan_end("rand", 3000);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
